// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide beside the EX-stage ALU.
// Owns the architectural HI/LO pair. Results are computed at the accepting
// edge and held in private result registers; HI/LO only change on the commit
// edge (or immediately for MTHI/MTLO), so no partial values are ever visible.
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDCtrl,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Counter only needs to hold latency-1 of the longer operation.
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          busy_reg, busy_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   res_hi_reg, res_hi_next;
  logic [31:0]   res_lo_reg, res_lo_next;
  logic          divz_reg, divz_next;

  // Arithmetic datapath, evaluated on the operands present at the accepting edge.
  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, dvsr, uq, ur, quot, rem;

  // Sign-extended operands multiplied modulo 2^64 give the exact signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes, then fixes signs: the quotient truncates
  // toward zero and the remainder follows the dividend. 0x80000000 / -1 falls
  // out naturally as 0x80000000 rem 0 because the magnitude is taken unsigned.
  assign div_signed = (MDCtrl == OP_DIV);
  assign a_neg      = div_signed & A[31];
  assign b_neg      = div_signed & B[31];
  assign a_mag      = a_neg ? (32'd0 - A) : A;
  assign b_mag      = b_neg ? (32'd0 - B) : B;
  assign dvsr       = (B == 32'd0) ? 32'd1 : b_mag;  // result unused when B is zero
  assign uq         = a_mag / dvsr;
  assign ur         = a_mag % dvsr;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;

  // State and architectural registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      res_hi_reg <= 32'd0;
      res_lo_reg <= 32'd0;
      divz_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      busy_reg   <= busy_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      res_hi_reg <= res_hi_next;
      res_lo_reg <= res_lo_next;
      divz_reg   <= divz_next;
    end
  end

  // Next-state: accept only in IDLE, count down while busy, commit at zero.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    busy_next   = busy_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    res_hi_next = res_hi_reg;
    res_lo_next = res_lo_reg;
    divz_next   = divz_reg;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          case (MDCtrl)
            OP_MULT, OP_MULTU: begin
              res_hi_next = (MDCtrl == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
              res_lo_next = (MDCtrl == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
              divz_next   = 1'b0;
              count_next  = MUL_LOAD;
              busy_next   = 1'b1;
              state_next  = MUL;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_next = rem;
              res_lo_next = quot;
              divz_next   = (B == 32'd0);
              count_next  = DIV_LOAD;
              busy_next   = 1'b1;
              state_next  = DIV;
            end
            OP_MTHI: hi_next = A;
            OP_MTLO: lo_next = A;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        // Any Start seen here is deliberately ignored.
        if (count_reg != '0) begin
          count_next = count_reg - 1'b1;
        end else begin
          if (!divz_reg) begin
            hi_next = res_hi_reg;
            lo_next = res_lo_reg;
          end
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign Busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit that sits beside the ALU in the EX stage and owns the HI/LO register pair. It accepts a start pulse with two 32-bit operands, holds `Busy` for a fixed latency and then commits the result to HI/LO. The hazard logic stalls any later HI/LO instruction while `Busy` or `Start` is high. `MTHI`/`MTLO` writes go through the same unit.

## Interface
- `MUL_CYCLES`, default 5: multiply latency in cycles, counted from the cycle after `Start` is accepted.
- `DIV_CYCLES`, default 10: divide latency in cycles, counted the same way.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock; the reset polarity and synchronicity are fixed.
- `A`  in  32  rs operand; dividend for divides, write data for `MTHI`/`MTLO`.
- `B`  in  32  rt operand; divisor for divides.
- `MDCtrl`  in  3  0 `MULT`, 1 `MULTU`, 2 `DIV`, 3 `DIVU`, 4 `MTHI`, 5 `MTLO`; 6–7 no-op.
- `Start`  in  1  one-cycle request, sampled at the rising edge.
- `Busy`  out  1  high while a multiply or divide is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- FSM states: IDLE, MUL, DIV. `reset` forces IDLE, `Busy`=0, `HI`=0, `LO`=0, counter=0, and clears the internal result registers.
- **IDLE, `Start`=1, MDCtrl 0/1:**
  - Latch the 64-bit product. `MULT` uses the signed product, `MULTU` the unsigned product.
  - Load counter=`MUL_CYCLES`-1 and go to MUL.
- **IDLE, `Start`=1, MDCtrl 2/3:**
  - Latch quotient and remainder; `DIV` is signed, `DIVU` is unsigned. Load counter=`DIV_CYCLES`-1 and go to DIV.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero: still go to DIV and run the full latency, but HI/LO are left unchanged at commit.
- **IDLE, `Start`=1, MDCtrl 4/5:** write `A` to HI (4) or LO (5) at that edge. No busy period; stay in IDLE.
- **IDLE, `Start`=1, MDCtrl 6/7:** no effect.
- **MUL/DIV:**
  - Each edge: if counter≠0, decrement it.
  - If counter=0: commit HI = product[63:32] or remainder, LO = product[31:0] or quotient. Then go to IDLE.
- **`Start` while in MUL/DIV:** ignored entirely, including `MTHI`/`MTLO`. The pipeline never issues this; the bench checks that it is ignored.
- **Operand capture:** operands are used only at the accepting edge. Later changes on `A`/`B`/`MDCtrl` have no effect.
- **Intermediate values:** HI/LO never show partial or intermediate values; the old values stay visible until the commit edge.
- **Arithmetic:** 32×32→64 product with no truncation. The divider may be combinational at capture or iterative (restoring, 1 bit/cycle). In either case the visible latency is exactly the parameter value. An iterative divider requires `DIV_CYCLES` ≥ 32 or a multi-bit-per-cycle step; with the default of 10, capture at `Start` is required.

## Timing
- `Start` is accepted at edge k.
- `Busy` is registered: it rises after edge k and falls after edge k+N, where N = `MUL_CYCLES` or `DIV_CYCLES`. So `Busy` is high for exactly N cycles.
- HI/LO take the new result at edge k+N, the same edge where `Busy` falls.
- A new `Start` is accepted at edge k+N+1 at the earliest, the first edge sampled with `Busy`=0. Back-to-back operations therefore have one idle cycle between busy periods.
- `MTHI`/`MTLO`: HI/LO update at the accepting edge k; `Busy` stays 0.
- `reset` asserted mid-operation: `Busy`, HI and LO go to 0 immediately (asynchronously). The in-flight result is discarded; no commit after reset is released.
- `reset` released: the first accepted `Start` is at the first rising edge with `reset` low.

## Test plan
- **Reset values:** assert `reset` mid-cycle → `Busy`=0, HI=0, LO=0 immediately, without waiting for a clock edge.
- **MULT signed:**
  - Stimulus: A=0xFFFFFFFE (−2), B=3, `MULT`.
  - Required: `Busy` high for 5 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFA at the 5th edge.
  - Repeat with `MULTU`: HI=0x00000002, LO=0xFFFFFFFA.
- **DIV/DIVU:**
  - A=0xFFFFFFF9 (−7), B=2, `DIV` → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Same operands with `DIVU` → LO=0x7FFFFFFC, HI=1.
  - A=0x80000000, B=0xFFFFFFFF, `DIV` → LO=0x80000000, HI=0.
- **Divide by zero:** preload HI=0x1234 and LO=0x5678 with `MTHI`/`MTLO`, then `DIV` with B=0 → `Busy` high 10 cycles; HI/LO stay 0x1234/0x5678.
- **Ignored start:**
  - Start `MULT` 2×3, then pulse `Start` with `MTLO` A=0xDEAD and `DIV` while `Busy`=1.
  - Required: LO=6 and HI=0 at the commit edge; `Busy` falls on schedule; no divide follows.
  - Operand changes on `A`/`B` during busy also have no effect.
- **Reset mid-operation:** assert `reset` on the 3rd busy cycle of `DIV` → HI=LO=0 and `Busy`=0. After `reset` is released, no commit occurs. A new `MTHI` with A=7 then gives HI=7 at the next edge.
